avalon_mem_arbiter: RTL and testbench
=====================================

Name: avalon_mem_arbiter

Overview:
- Shares one Avalon-MM memory slave between two CPU requesters: instruction fetch (I) and data load/store (D).
- Sits between the MIPS core's two Avalon master interfaces and the single memory bus.
- Grants one requester at a time with round-robin fairness, forwards the slave's waitrequest handshake, and routes readdata back.
- Flags slave hangs with a watchdog timeout.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits. byteenable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, maximum granted cycles with m_waitrequest high before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction fetch request.
- i_address  in  ADDR_W  fetch byte address.
- i_waitrequest  out  1  high = stall I; low for exactly the completing cycle.
- i_readdata  out  DATA_W  fetch data, valid when i_read && !i_waitrequest.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_address  in  ADDR_W  data byte address.
- d_writedata  in  DATA_W  store data.
- d_byteenable  in  DATA_W/8  byte lanes for D access.
- d_waitrequest  out  1  high = stall D.
- d_readdata  out  DATA_W  load data, valid when d_read && !d_waitrequest.
- m_address  out  ADDR_W  to memory slave.
- m_read  out  1  to memory slave.
- m_write  out  1  to memory slave.
- m_writedata  out  DATA_W  to memory slave.
- m_byteenable  out  DATA_W/8  to memory slave.
- m_waitrequest  in  1  from memory slave.
- m_readdata  in  DATA_W  from memory slave.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.

Behaviour:
- Requester protocol: a requester holds its command (read/write, address, data, byteenable) stable while its waitrequest is high. A transfer completes in the cycle its waitrequest is low.
- FSM states and transitions:
  - IDLE: if any request is pending, register the winner and go to GRANT_I or GRANT_D next edge.
  - GRANT_I / GRANT_D: the granted requester's inputs drive m_* combinationally. On m_waitrequest==0, the transfer completes in the same cycle and the FSM returns to IDLE.
  - ABORT: one cycle, then IDLE.
- Latency: request at cycle N gives the grant at edge N+1. With a zero-wait slave, completion is in cycle N+1; back-to-back transfers from one requester take 2 cycles each.
- Arbitration:
  - last_grant register, reset value = I.
  - Both pending in IDLE: grant the requester not in last_grant.
  - Single pending: grant it.
  - last_grant updates on every completion.
- Outputs outside a grant:
  - m_read = m_write = 0; m_address, m_writedata, m_byteenable = 0.
  - i_waitrequest = d_waitrequest = 1.
  - i_readdata = d_readdata = 0.
- During GRANT_I: m_byteenable = all ones, m_write = 0, i_readdata = m_readdata. d_waitrequest stays 1 throughout.
- During GRANT_D: d_readdata = m_readdata. i_waitrequest stays 1 throughout.
- d_read && d_write together: write wins, m_read forced 0.
- Granted requester drops its request mid-grant: m_read/m_write follow the live input and go to 0 the same cycle. The FSM returns to IDLE next edge, no completion is signalled, and last_grant is unchanged.
- Watchdog:
  - Counter clears on entering a GRANT state and increments each granted cycle with m_waitrequest high.
  - On reaching TIMEOUT_CYCLES: deassert m_read/m_write that cycle, set timeout_err, go to ABORT.
  - In that abort cycle, pulse the granted requester's waitrequest low with readdata = 32'hDEADBEEF (completes the stuck requester).
  - Counter saturates and never wraps.
- Reset: asserting reset mid-transfer immediately forces IDLE and all outputs to their reset values above (waitrequests = 1, timeout_err = 0, counter = 0).

Decomposition:
- Package avalon_arb_pkg: enum arb_state_t {IDLE, GRANT_I, GRANT_D, ABORT}, enum requester_t {REQ_I, REQ_D}, constant ABORT_READDATA = 32'hDEADBEEF.
- One sub-module: arb_watchdog (saturating counter with clear/enable and a terminal-count output).
- Muxing and FSM stay in the top level.

Test Plan:
- Only I reads 0xBFC00000, slave zero-wait returning 0x3C011234 -> grant at cycle 1; i_waitrequest low in cycle 1 with i_readdata = 0x3C011234; d_waitrequest stays 1.
- I and D request simultaneously from reset (D write 0x00000010, data 0xAABBCCDD, byteenable 4'b0001) -> D granted first (last_grant = I), m_write = 1 with matching address/data/byteenable. I granted on the next IDLE pass; m_byteenable = 4'hF for the I transfer.
- Slave holds waitrequest 3 cycles on a D read of 0x00000004 -> m_read held 3 cycles; d_waitrequest low on the 4th granted cycle with d_readdata = m_readdata.
- D asserts d_read and d_write together -> m_write = 1, m_read = 0.
- TIMEOUT_CYCLES = 4, slave waitrequest stuck high on an I fetch -> after 4 stalled cycles m_read drops and the FSM enters ABORT. i_waitrequest pulses low with 0xDEADBEEF, timeout_err = 1 and stays set.
- Reset asserted mid-GRANT_D with slave stalled -> immediately m_write = 0, both waitrequests = 1, state IDLE; the first grant after reset goes to D when both requesters are pending.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM memory arbiter.
//   arb_state_t    : arbiter FSM states
//   requester_t    : identifies the instruction (I) or data (D) requester
//   ABORT_READDATA : readdata returned to a requester whose access was aborted
package avalon_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      ABORT
   } arb_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } requester_t;

   localparam logic [31:0] ABORT_READDATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating stall counter used to detect a hung memory slave.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (held while no grant is active)
//   enable   : count one stalled cycle
//   expired  : count has reached LIMIT (never asserted when LIMIT == 0)
module arb_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (LIMIT != 0) && (count == CW'(LIMIT));

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM memory slave between the CPU
// instruction-fetch (I) and data load/store (D) masters.
//   clk, reset             : clock, asynchronous active-high reset
//   i_read/i_address       : fetch request;   i_waitrequest/i_readdata back to I
//   d_read/d_write/d_*     : data request;    d_waitrequest/d_readdata back to D
//   m_*                    : Avalon-MM master port toward the memory slave
//   timeout_err            : sticky flag, set when the watchdog aborts a grant
module avalon_mem_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic                i_waitrequest,
   output logic [DATA_W-1:0]   i_readdata,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W-1:0]   d_writedata,
   input  logic [DATA_W/8-1:0] d_byteenable,
   output logic                d_waitrequest,
   output logic [DATA_W-1:0]   d_readdata,
   output logic [ADDR_W-1:0]   m_address,
   output logic                m_read,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic                m_waitrequest,
   input  logic [DATA_W-1:0]   m_readdata,
   output logic                timeout_err
);

   arb_state_t state, state_nxt;
   requester_t last_grant, last_nxt;
   requester_t owner, owner_nxt;
   requester_t winner;
   logic       timeout_nxt;
   logic       granted;
   logic       wd_expired;
   logic       d_pend;

   assign granted = (state == GRANT_I) || (state == GRANT_D);
   assign d_pend  = d_read || d_write;

   arb_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (reset),
      .clear   (!granted),
      .enable  (granted && m_waitrequest),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= REQ_I;
         owner       <= REQ_I;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_nxt;
         owner       <= owner_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      last_nxt      = last_grant;
      owner_nxt     = owner;
      timeout_nxt   = timeout_err;
      winner        = REQ_I;
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = '0;
      m_byteenable  = '0;
      i_waitrequest = 1'b1;
      i_readdata    = '0;
      d_waitrequest = 1'b1;
      d_readdata    = '0;

      case (state)
         IDLE: begin
            if (i_read || d_pend) begin
               if (i_read && d_pend) begin
                  winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
               end else begin
                  winner = i_read ? REQ_I : REQ_D;
               end
               owner_nxt = winner;
               state_nxt = (winner == REQ_I) ? GRANT_I : GRANT_D;
            end
         end

         GRANT_I: begin
            m_address    = i_address;
            m_byteenable = '1;
            m_read       = i_read && !wd_expired;
            i_readdata   = m_readdata;
            if (wd_expired) begin
               timeout_nxt = 1'b1;
               state_nxt   = ABORT;
            end else if (!i_read) begin
               // Request withdrawn: release the bus without a completion.
               state_nxt = IDLE;
            end else if (!m_waitrequest) begin
               i_waitrequest = 1'b0;
               last_nxt      = REQ_I;
               state_nxt     = IDLE;
            end
         end

         GRANT_D: begin
            m_address    = d_address;
            m_writedata  = d_writedata;
            m_byteenable = d_byteenable;
            // A simultaneous read and write is issued as a write.
            m_write      = d_write && !wd_expired;
            m_read       = d_read && !d_write && !wd_expired;
            d_readdata   = m_readdata;
            if (wd_expired) begin
               timeout_nxt = 1'b1;
               state_nxt   = ABORT;
            end else if (!d_pend) begin
               state_nxt = IDLE;
            end else if (!m_waitrequest) begin
               d_waitrequest = 1'b0;
               last_nxt      = REQ_D;
               state_nxt     = IDLE;
            end
         end

         ABORT: begin
            // Complete the stuck requester with a recognisable poison value.
            if (owner == REQ_I) begin
               i_waitrequest = 1'b0;
               i_readdata    = DATA_W'(ABORT_READDATA);
            end else begin
               d_waitrequest = 1'b0;
               d_readdata    = DATA_W'(ABORT_READDATA);
            end
            last_nxt  = owner;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
module tb_avalon_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic          i_waitrequest;
   logic [DW-1:0] i_readdata;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [DW-1:0] d_writedata;
   logic [3:0]    d_byteenable;
   logic          d_waitrequest;
   logic [DW-1:0] d_readdata;
   logic [AW-1:0] m_address;
   logic          m_read;
   logic          m_write;
   logic [DW-1:0] m_writedata;
   logic [3:0]    m_byteenable;
   logic          m_waitrequest;
   logic [DW-1:0] m_readdata;
   logic          timeout_err;

   always #5 clk = ~clk;

   avalon_mem_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_waitrequest (i_waitrequest),
      .i_readdata    (i_readdata),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_byteenable  (d_byteenable),
      .d_waitrequest (d_waitrequest),
      .d_readdata    (d_readdata),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .timeout_err   (timeout_err)
   );

   // Slave model: 16-word memory, programmable wait states, stuck mode.
   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   int unsigned stall_cnt;
   int unsigned stall_req;
   logic        stuck;

   assign m_waitrequest = stuck || (stall_cnt < stall_req);
   assign m_readdata    = mem[m_address[5:2]];

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i == 0) ? 32'h3C011234 : (32'h5A5A0000 | 32'(i * 17));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] data,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
         stall_cnt <= 0;
      end else if (m_read || m_write) begin
         if (!m_waitrequest) begin
            if (m_write) mem[m_address[5:2]] <= merge(mem[m_address[5:2]], m_writedata, m_byteenable);
            stall_cnt <= 0;
         end else begin
            stall_cnt <= stall_cnt + 1;
         end
      end else begin
         stall_cnt <= 0;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ref_init();
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ref_init();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_mrd"}, m_read, 0);
      chk({tag, "_mwr"}, m_write, 0);
      chk({tag, "_iwait"}, i_waitrequest, 1);
      chk({tag, "_dwait"}, d_waitrequest, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1);
   end

   int          owner;
   int          last;
   logic        pi, pd, di, dd;
   int unsigned kind;

   initial begin
      reset = 1'b1; stuck = 1'b0; stall_req = 0;
      i_read = 0; i_address = '0; d_read = 0; d_write = 0;
      d_address = '0; d_writedata = '0; d_byteenable = '0;
      ref_init();
      next_cycle();
      reset = 1'b0;

      // Reset state
      sample();
      chk_idle("rst");
      chk("rst_irdata", i_readdata, 0);
      chk("rst_drdata", d_readdata, 0);
      chk("rst_maddr", m_address, 0);
      chk("rst_mbe", m_byteenable, 0);
      chk("rst_terr", timeout_err, 0);
      next_cycle();

      // Single I fetch, zero-wait slave
      i_read = 1; i_address = 32'hBFC00000;
      sample(); chk_idle("t1_req");
      next_cycle();
      sample();
      chk("t1_mrd", m_read, 1);
      chk("t1_maddr", m_address, 32'hBFC00000);
      chk("t1_mbe", m_byteenable, 4'hF);
      chk("t1_iwait", i_waitrequest, 0);
      chk("t1_irdata", i_readdata, 32'h3C011234);
      chk("t1_dwait", d_waitrequest, 1);
      next_cycle();
      i_read = 0;
      sample(); chk_idle("t1_after");
      next_cycle();

      // Simultaneous I and D from reset: D first
      do_reset();
      d_write = 1; d_address = 32'h10; d_writedata = 32'hAABBCCDD; d_byteenable = 4'b0001;
      i_read = 1; i_address = 32'h4;
      sample(); chk_idle("t2_req");
      next_cycle();
      sample();
      chk("t2_mwr", m_write, 1);
      chk("t2_mrd", m_read, 0);
      chk("t2_maddr", m_address, 32'h10);
      chk("t2_mwdata", m_writedata, 32'hAABBCCDD);
      chk("t2_mbe", m_byteenable, 4'b0001);
      chk("t2_dwait", d_waitrequest, 0);
      chk("t2_iwait_d", i_waitrequest, 1);
      ref_mem[4] = merge(ref_mem[4], 32'hAABBCCDD, 4'b0001);
      next_cycle();
      d_write = 0;
      sample(); chk_idle("t2_gap");
      next_cycle();
      sample();
      chk("t2_i_mrd", m_read, 1);
      chk("t2_i_maddr", m_address, 32'h4);
      chk("t2_i_mbe", m_byteenable, 4'hF);
      chk("t2_i_iwait", i_waitrequest, 0);
      chk("t2_i_irdata", i_readdata, ref_mem[1]);
      next_cycle();
      i_read = 0;

      // D read with 3 wait states
      d_read = 1; d_address = 32'h4; stall_req = 3;
      sample(); chk_idle("t3_req");
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("t3_mrd_held", m_read, 1);
         chk("t3_dwait_held", d_waitrequest, 1);
         next_cycle();
      end
      sample();
      chk("t3_dwait", d_waitrequest, 0);
      chk("t3_drdata", d_readdata, ref_mem[1]);
      next_cycle();
      d_read = 0; stall_req = 0;

      // Read and write together: write wins
      d_read = 1; d_write = 1; d_address = 32'h10; d_writedata = 32'h11223344; d_byteenable = 4'hF;
      sample(); chk_idle("t4_req");
      next_cycle();
      sample();
      chk("t4_mwr", m_write, 1);
      chk("t4_mrd", m_read, 0);
      chk("t4_dwait", d_waitrequest, 0);
      ref_mem[4] = 32'h11223344;
      next_cycle();
      d_write = 0;
      sample();
      next_cycle();
      sample();
      chk("t4_rb_mrd", m_read, 1);
      chk("t4_rb_drdata", d_readdata, ref_mem[4]);
      chk("t4_rb_dwait", d_waitrequest, 0);
      next_cycle();
      d_read = 0;

      // Watchdog abort on a stuck I fetch
      stuck = 1; i_read = 1; i_address = 32'h8;
      sample(); chk_idle("t5_req");
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         sample();
         chk("t5_mrd_stall", m_read, 1);
         chk("t5_iwait_stall", i_waitrequest, 1);
         next_cycle();
      end
      sample();
      chk("t5_mrd_drop", m_read, 0);
      chk("t5_iwait_drop", i_waitrequest, 1);
      chk("t5_terr_pre", timeout_err, 0);
      next_cycle();
      sample();
      chk("t5_abort_iwait", i_waitrequest, 0);
      chk("t5_abort_irdata", i_readdata, 32'hDEADBEEF);
      chk("t5_abort_terr", timeout_err, 1);
      chk("t5_abort_dwait", d_waitrequest, 1);
      chk("t5_abort_mrd", m_read, 0);
      next_cycle();
      i_read = 0; stuck = 0;
      sample();
      chk("t5_terr_sticky", timeout_err, 1);
      chk_idle("t5_after");
      next_cycle();

      // Reset mid GRANT_D with stalled slave
      stuck = 1; d_write = 1; d_address = 32'h20; d_writedata = 32'hCAFEF00D; d_byteenable = 4'hF;
      sample();
      next_cycle();
      sample();
      chk("t6_mwr_pre", m_write, 1);
      chk("t6_dwait_pre", d_waitrequest, 1);
      reset = 1'b1;
      ref_init();
      #1;
      chk("t6_mwr_rst", m_write, 0);
      chk("t6_dwait_rst", d_waitrequest, 1);
      chk("t6_iwait_rst", i_waitrequest, 1);
      chk("t6_terr_rst", timeout_err, 0);
      i_read = 1; i_address = 32'hC; stuck = 0;
      next_cycle();
      reset = 1'b0;
      sample(); chk_idle("t6_idle");
      next_cycle();
      sample();
      chk("t6_first_mwr", m_write, 1);
      chk("t6_first_dwait", d_waitrequest, 0);
      chk("t6_first_iwait", i_waitrequest, 1);
      ref_mem[8] = 32'hCAFEF00D;
      next_cycle();
      d_write = 0;
      sample();
      next_cycle();
      sample();
      chk("t6_i_iwait", i_waitrequest, 0);
      chk("t6_i_irdata", i_readdata, ref_mem[3]);
      next_cycle();
      i_read = 0;

      // Randomized traffic against the reference model (last grant was I)
      owner = 0; last = 1; pi = 0; pd = 0; di = 0; dd = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (owner == 1 && di) begin
            last = 1; owner = 0; pi = 0; i_read = 0;
         end else if (owner == 2 && dd) begin
            last = 2; owner = 0; pd = 0;
            if (d_write) ref_mem[d_address[5:2]] = merge(ref_mem[d_address[5:2]], d_writedata, d_byteenable);
            d_read = 0; d_write = 0;
         end else if (owner == 0) begin
            if (pi && pd) owner = (last == 1) ? 2 : 1;
            else if (pi) owner = 1;
            else if (pd) owner = 2;
         end
         if (!pi && $urandom_range(0, 2) == 0) begin
            pi = 1; i_read = 1; i_address = $urandom() & 32'hFFFFFFFC;
         end
         if (!pd && $urandom_range(0, 2) == 0) begin
            pd = 1;
            kind = $urandom_range(0, 2);
            d_read = (kind != 1);
            d_write = (kind != 0);
            d_address = $urandom() & 32'hFFFFFFFC;
            d_writedata = $urandom();
            d_byteenable = 4'($urandom_range(0, 15));
         end
         stall_req = $urandom_range(0, 2);
         sample();
         di = 0; dd = 0;
         case (owner)
            0: chk_idle("rnd_idle");
            1: begin
               chk("rnd_i_mrd", m_read, 1);
               chk("rnd_i_mwr", m_write, 0);
               chk("rnd_i_maddr", m_address, i_address);
               chk("rnd_i_mbe", m_byteenable, 4'hF);
               chk("rnd_i_dwait", d_waitrequest, 1);
               chk("rnd_i_iwait", i_waitrequest, m_waitrequest);
               di = (i_waitrequest === 1'b0);
               if (di) chk("rnd_i_irdata", i_readdata, ref_mem[i_address[5:2]]);
            end
            default: begin
               chk("rnd_d_mwr", m_write, d_write);
               chk("rnd_d_mrd", m_read, d_read && !d_write);
               chk("rnd_d_maddr", m_address, d_address);
               chk("rnd_d_mbe", m_byteenable, d_byteenable);
               chk("rnd_d_mwdata", m_writedata, d_writedata);
               chk("rnd_d_iwait", i_waitrequest, 1);
               chk("rnd_d_dwait", d_waitrequest, m_waitrequest);
               dd = (d_waitrequest === 1'b0);
               if (dd && !d_write) chk("rnd_d_drdata", d_readdata, ref_mem[d_address[5:2]]);
            end
         endcase
         next_cycle();
      end
      chk("rnd_terr", timeout_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
